// File: rtl/coalescing_store_buffer.sv
// Coalescing store buffer for the MEM stage.
// Byte-enabled stores merge into the youngest entry when they hit the same word.
// Entries drain oldest-first over a valid/ready port.
// Loads are forwarded per byte lane from the youngest matching entry.
// A flush mode blocks new stores and waits until the buffer is empty.
module coalescing_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned BE_W  = DATA_W / 8,
    localparam int unsigned OFF_W = $clog2(BE_W),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic [BE_W-1:0]   push_be,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [DATA_W-1:0] load_data,
    output logic [BE_W-1:0]   load_hit_be,
    output logic              load_full,
    output logic              drain_valid,
    output logic [ADDR_W-1:0] drain_addr,
    output logic [DATA_W-1:0] drain_data,
    output logic [BE_W-1:0]   drain_be,
    input  logic              drain_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam int unsigned WORD_W = ADDR_W - OFF_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flush_done_q, flush_done_d;

    logic               ent_valid_q [DEPTH];
    logic               ent_valid_d [DEPTH];
    logic [WORD_W-1:0]  ent_word_q  [DEPTH];
    logic [WORD_W-1:0]  ent_word_d  [DEPTH];
    logic [DATA_W-1:0]  ent_data_q  [DEPTH];
    logic [DATA_W-1:0]  ent_data_d  [DEPTH];
    logic [BE_W-1:0]    ent_be_q    [DEPTH];
    logic [BE_W-1:0]    ent_be_d    [DEPTH];

    logic [WORD_W-1:0]  push_word;
    logic [WORD_W-1:0]  load_word;
    logic [PTR_W-1:0]   youngest;
    logic [DATA_W-1:0]  lane_mask;
    logic               empty_w;
    logic               full_w;
    logic               coalesce_possible;
    logic               push_ready_w;
    logic               push_fire;
    logic               drain_fire;
    logic               do_merge;
    logic               do_alloc;

    logic [DATA_W-1:0]  fwd_data;
    logic [BE_W-1:0]    fwd_be;
    int unsigned        fwd_slot;
    logic [PTR_W-1:0]   fwd_idx;

    // Address offset bits inside a word play no part in matching.
    logic               unused_offset_bits;
    assign unused_offset_bits = ^{push_addr[OFF_W-1:0], load_addr[OFF_W-1:0]};

    // Push/drain handshake decode and coalescing decision.
    always_comb begin
        push_word         = push_addr[ADDR_W-1:OFF_W];
        load_word         = load_addr[ADDR_W-1:OFF_W];
        youngest          = (tail_q == '0) ? PTR_W'(DEPTH - 1) : tail_q - 1'b1;
        empty_w           = (count_q == '0);
        full_w            = (count_q == CNT_W'(DEPTH));
        coalesce_possible = !empty_w && ent_valid_q[youngest] &&
                            (ent_word_q[youngest] == push_word);
        push_ready_w      = (state_q == ST_RUN) && (!full_w || coalesce_possible);
        push_fire         = push_valid && push_ready_w;
        drain_fire        = !empty_w && drain_ready;
        // The youngest entry cannot absorb a push while it is leaving as the head.
        do_merge          = push_fire && coalesce_possible &&
                            !((youngest == head_q) && drain_fire);
        // A zero byte-enable push is accepted but leaves no trace.
        do_alloc          = push_fire && !do_merge && (push_be != '0);
        lane_mask         = '0;
        for (int unsigned b = 0; b < BE_W; b++) begin
            lane_mask[8*b +: 8] = {8{push_be[b]}};
        end
    end

    // Next-state of entry storage, pointers and occupancy.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_valid_d[i] = ent_valid_q[i];
            ent_word_d[i]  = ent_word_q[i];
            ent_data_d[i]  = ent_data_q[i];
            ent_be_d[i]    = ent_be_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (do_merge) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (push_be[b]) begin
                    ent_data_d[youngest][8*b +: 8] = push_data[8*b +: 8];
                end
            end
            ent_be_d[youngest] = ent_be_q[youngest] | push_be;
        end

        if (do_alloc) begin
            ent_valid_d[tail_q] = 1'b1;
            ent_word_d[tail_q]  = push_word;
            ent_data_d[tail_q]  = push_data & lane_mask;
            ent_be_d[tail_q]    = push_be;
            tail_d              = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end

        if (drain_fire) begin
            ent_valid_d[head_q] = 1'b0;
            ent_be_d[head_q]    = '0;
            head_d              = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
        end

        if (do_alloc && !drain_fire) begin
            count_d = count_q + 1'b1;
        end else if (!do_alloc && drain_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    // Flush sequencing: completion is signalled one cycle after the buffer is empty.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    if (empty_w && !do_alloc) begin
                        flush_done_d = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (empty_w) begin
                    state_d      = ST_RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Per-lane forwarding: walk oldest to youngest so younger hits overwrite older ones.
    always_comb begin
        fwd_data = '0;
        fwd_be   = '0;
        fwd_slot = 0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_slot = 32'(head_q) + i;
            if (fwd_slot >= DEPTH) begin
                fwd_slot = fwd_slot - DEPTH;
            end
            fwd_idx = PTR_W'(fwd_slot);
            if ((i < 32'(count_q)) && ent_valid_q[fwd_idx] &&
                (ent_word_q[fwd_idx] == load_word)) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (ent_be_q[fwd_idx][b]) begin
                        fwd_data[8*b +: 8] = ent_data_q[fwd_idx][8*b +: 8];
                        fwd_be[b]          = 1'b1;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            flush_done_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_valid_q[i] <= 1'b0;
                ent_word_q[i]  <= '0;
                ent_data_q[i]  <= '0;
                ent_be_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            flush_done_q <= flush_done_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_valid_q[i] <= ent_valid_d[i];
                ent_word_q[i]  <= ent_word_d[i];
                ent_data_q[i]  <= ent_data_d[i];
                ent_be_q[i]    <= ent_be_d[i];
            end
        end
    end

    assign push_ready  = push_ready_w;
    assign load_data   = fwd_data;
    assign load_hit_be = fwd_be;
    assign load_full   = &fwd_be;
    assign drain_valid = !empty_w;
    assign drain_addr  = {ent_word_q[head_q], {OFF_W{1'b0}}};
    assign drain_data  = ent_data_q[head_q];
    assign drain_be    = ent_be_q[head_q];
    assign flush_done  = flush_done_q;
    assign count       = count_q;
    assign empty       = empty_w;

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Testbench for coalescing_store_buffer (DEPTH=4, 32-bit address and data).
module tb_coalescing_store_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        push_valid = 1'b0;
    logic [31:0] push_addr = '0;
    logic [31:0] push_data = '0;
    logic [3:0]  push_be = '0;
    logic        push_ready;
    logic [31:0] load_addr = 32'h40;
    logic [31:0] load_data;
    logic [3:0]  load_hit_be;
    logic        load_full;
    logic        drain_valid;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  drain_be;
    logic        drain_ready = 1'b0;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [2:0]  count;
    logic        empty;

    int n_pass  = 0;
    int n_total = 0;

    coalescing_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data),
        .push_be(push_be), .push_ready(push_ready),
        .load_addr(load_addr), .load_data(load_data), .load_hit_be(load_hit_be),
        .load_full(load_full),
        .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data),
        .drain_be(drain_be), .drain_ready(drain_ready),
        .flush(flush), .flush_done(flush_done), .count(count), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        pv;
        logic [31:0] pa;
        logic [31:0] pd;
        logic [3:0]  pbe;
        logic        dr;
        logic [31:0] la;
        int          e_cnt;
        logic        e_prdy;
        logic        e_dv;
        logic [31:0] e_da;
        logic [31:0] e_dd;
        logic [3:0]  e_dbe;
        logic [31:0] e_ld;
        logic [3:0]  e_lbe;
    } vec_t;

    function automatic vec_t mk(string n, logic pv, logic [31:0] pa, logic [31:0] pd,
                                logic [3:0] pbe, logic dr, logic [31:0] la, int cnt,
                                logic prdy, logic dv, logic [31:0] da, logic [31:0] dd,
                                logic [3:0] dbe, logic [31:0] ld, logic [3:0] lbe);
        vec_t v;
        v.name = n; v.pv = pv; v.pa = pa; v.pd = pd; v.pbe = pbe; v.dr = dr; v.la = la;
        v.e_cnt = cnt; v.e_prdy = prdy; v.e_dv = dv; v.e_da = da; v.e_dd = dd;
        v.e_dbe = dbe; v.e_ld = ld; v.e_lbe = lbe;
        return v;
    endfunction

    function automatic logic [31:0] bmask(logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  be;
    } ment_t;

    vec_t vecs[$];

    initial begin
        // name, pv, pa, pd, pbe, dr, la, count, push_ready, drain_valid, d_addr, d_data, d_be, l_data, l_be
        vecs.push_back(mk("t2_p0", 1, 32'h00, 32'hA0A0A0A0, 4'hF, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t2_p1", 1, 32'h04, 32'hA1A1A1A1, 4'hF, 0, 32'h00, 1, 1, 1, 32'h00, 32'hA0A0A0A0, 4'hF, 32'hA0A0A0A0, 4'hF));
        vecs.push_back(mk("t2_p2", 1, 32'h08, 32'hA2A2A2A2, 4'hF, 0, 32'h04, 2, 1, 1, 32'h00, 32'hA0A0A0A0, 4'hF, 32'hA1A1A1A1, 4'hF));
        vecs.push_back(mk("t2_p3", 1, 32'h0C, 32'hA3A3A3A3, 4'hF, 0, 32'h40, 3, 1, 1, 32'h00, 32'hA0A0A0A0, 4'hF, 0, 0));
        vecs.push_back(mk("t2_coal_full", 1, 32'h0E, 32'h00550000, 4'h4, 0, 32'h0C, 4, 1, 1, 32'h00, 32'hA0A0A0A0, 4'hF, 32'hA3A3A3A3, 4'hF));
        vecs.push_back(mk("t2_reject", 1, 32'h10, 32'hA4A4A4A4, 4'hF, 1, 32'h0C, 4, 0, 1, 32'h00, 32'hA0A0A0A0, 4'hF, 32'hA355A3A3, 4'hF));
        vecs.push_back(mk("t2_after", 0, 32'h40, 0, 0, 0, 32'h00, 3, 1, 1, 32'h04, 32'hA1A1A1A1, 4'hF, 0, 0));
        vecs.push_back(mk("t2_d1", 0, 32'h40, 0, 0, 1, 32'h10, 3, 1, 1, 32'h04, 32'hA1A1A1A1, 4'hF, 0, 0));
        vecs.push_back(mk("t2_d2", 0, 32'h40, 0, 0, 1, 32'h40, 2, 1, 1, 32'h08, 32'hA2A2A2A2, 4'hF, 0, 0));
        vecs.push_back(mk("t2_d3", 0, 32'h40, 0, 0, 1, 32'h40, 1, 1, 1, 32'h0C, 32'hA355A3A3, 4'hF, 0, 0));
        vecs.push_back(mk("t2_empty", 0, 32'h40, 0, 0, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t3_p0", 1, 32'h11, 32'h0000AA00, 4'h2, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t3_p1", 1, 32'h13, 32'hBB000000, 4'h8, 0, 32'h40, 1, 1, 1, 32'h10, 32'h0000AA00, 4'h2, 0, 0));
        vecs.push_back(mk("t3_merged", 0, 32'h40, 0, 0, 0, 32'h12, 1, 1, 1, 32'h10, 32'hBB00AA00, 4'hA, 32'hBB00AA00, 4'hA));
        vecs.push_back(mk("t3_drain", 0, 32'h40, 0, 0, 1, 32'h40, 1, 1, 1, 32'h10, 32'hBB00AA00, 4'hA, 0, 0));
        vecs.push_back(mk("t4_p0", 1, 32'h20, 32'h11111111, 4'hF, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t4_p1", 1, 32'h24, 32'h33333333, 4'hF, 0, 32'h22, 1, 1, 1, 32'h20, 32'h11111111, 4'hF, 32'h11111111, 4'hF));
        vecs.push_back(mk("t4_p2", 1, 32'h20, 32'h00000022, 4'h1, 0, 32'h24, 2, 1, 1, 32'h20, 32'h11111111, 4'hF, 32'h33333333, 4'hF));
        vecs.push_back(mk("t4_fwd", 0, 32'h40, 0, 0, 0, 32'h22, 3, 1, 1, 32'h20, 32'h11111111, 4'hF, 32'h11111122, 4'hF));
        vecs.push_back(mk("t4_miss", 0, 32'h40, 0, 0, 0, 32'h28, 3, 1, 1, 32'h20, 32'h11111111, 4'hF, 0, 0));
        vecs.push_back(mk("t4_drain_vis", 0, 32'h40, 0, 0, 1, 32'h20, 3, 1, 1, 32'h20, 32'h11111111, 4'hF, 32'h11111122, 4'hF));
        vecs.push_back(mk("t4_d1", 0, 32'h40, 0, 0, 1, 32'h20, 2, 1, 1, 32'h24, 32'h33333333, 4'hF, 32'h00000022, 4'h1));
        vecs.push_back(mk("t4_d2", 0, 32'h40, 0, 0, 1, 32'h40, 1, 1, 1, 32'h20, 32'h00000022, 4'h1, 0, 0));
        vecs.push_back(mk("ex_p0", 1, 32'h30, 32'h44444444, 4'hF, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("ex_p1", 1, 32'h30, 32'h00000055, 4'h1, 1, 32'h30, 1, 1, 1, 32'h30, 32'h44444444, 4'hF, 32'h44444444, 4'hF));
        vecs.push_back(mk("ex_new", 0, 32'h40, 0, 0, 1, 32'h40, 1, 1, 1, 32'h30, 32'h00000055, 4'h1, 0, 0));
        vecs.push_back(mk("ex_empty", 0, 32'h40, 0, 0, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0));

        // T1: reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("t1_empty", empty, 1);
        chk("t1_count", count, 0);
        chk("t1_push_ready", push_ready, 1);
        chk("t1_drain_valid", drain_valid, 0);
        chk("t1_load_hit_be", load_hit_be, 0);
        chk("t1_flush_done", flush_done, 0);

        // T2-T4 and the head-coalesce exception: table-driven
        foreach (vecs[k]) begin
            push_valid  = vecs[k].pv;
            push_addr   = vecs[k].pa;
            push_data   = vecs[k].pd;
            push_be     = vecs[k].pbe;
            drain_ready = vecs[k].dr;
            load_addr   = vecs[k].la;
            #1;
            chk({vecs[k].name, "_count"}, count, vecs[k].e_cnt);
            chk({vecs[k].name, "_push_ready"}, push_ready, vecs[k].e_prdy);
            chk({vecs[k].name, "_drain_valid"}, drain_valid, vecs[k].e_dv);
            if (vecs[k].e_dv) begin
                chk({vecs[k].name, "_drain_addr"}, drain_addr, vecs[k].e_da);
                chk({vecs[k].name, "_drain_data"}, drain_data, vecs[k].e_dd);
                chk({vecs[k].name, "_drain_be"}, drain_be, vecs[k].e_dbe);
            end
            chk({vecs[k].name, "_load_data"}, load_data, vecs[k].e_ld);
            chk({vecs[k].name, "_load_hit_be"}, load_hit_be, vecs[k].e_lbe);
            chk({vecs[k].name, "_load_full"}, load_full, vecs[k].e_lbe == 4'hF);
            step();
        end

        // T5: flush with three entries
        begin
            logic [31:0] exp_addr [3];
            int ri;
            int zero_cyc;
            int done_cyc;
            exp_addr[0] = 32'h50; exp_addr[1] = 32'h54; exp_addr[2] = 32'h58;
            push_be = 4'hF;
            drain_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                push_valid = 1'b1;
                push_addr  = exp_addr[i];
                push_data  = 32'h5000_0000 + i;
                #1;
                step();
            end
            push_valid  = 1'b0;
            flush       = 1'b1;
            drain_ready = 1'b1;
            #1;
            chk("t5_count_start", count, 3);
            chk("t5_drain0", drain_addr, exp_addr[0]);
            step();
            flush = 1'b0;
            ri = 1;
            zero_cyc = -1;
            done_cyc = -1;
            for (int c = 1; c < 20 && done_cyc < 0; c++) begin
                if (flush_done) begin
                    done_cyc = c;
                    chk("t5_ready_after", push_ready, 1);
                end else begin
                    chk("t5_push_ready_low", push_ready, 0);
                end
                if (drain_valid) begin
                    if (ri < 3) begin
                        chk("t5_drain_order", drain_addr, exp_addr[ri]);
                        ri++;
                    end else begin
                        chk("t5_extra_drain", drain_valid, 0);
                    end
                end
                if (count == 0 && zero_cyc < 0) zero_cyc = c;
                step();
            end
            chk("t5_retired", ri, 3);
            chk("t5_done_seen", done_cyc >= 0, 1);
            chk("t5_done_timing", done_cyc, zero_cyc + 1);
            chk("t5_done_one_cycle", flush_done, 0);
            chk("t5_ready_run", push_ready, 1);
        end

        // Flush while empty: done on the next cycle
        drain_ready = 1'b0;
        flush = 1'b1;
        #1;
        step();
        flush = 1'b0;
        chk("fe_done", flush_done, 1);
        chk("fe_ready", push_ready, 1);
        step();
        chk("fe_done_clear", flush_done, 0);

        // Reset asserted while in FLUSH
        push_be = 4'hF;
        for (int i = 0; i < 2; i++) begin
            push_valid = 1'b1;
            push_addr  = 32'h60 + 4 * i;
            push_data  = 32'h6666_0000 + i;
            step();
        end
        push_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("rf_in_flush_ready", push_ready, 0);
        chk("rf_in_flush_count", count, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rf_count", count, 0);
        chk("rf_empty", empty, 1);
        chk("rf_ready", push_ready, 1);
        chk("rf_drain_valid", drain_valid, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rf_no_done", flush_done, 0);
            step();
        end

        // T6: random push/drain against a reference queue
        begin
            ment_t mq[$];
            logic  mflush;
            logic  mdone;
            mflush = 1'b0;
            mdone  = 1'b0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                logic        rst_now;
                logic        coal;
                logic        e_prdy;
                logic        e_dv;
                logic        dfire;
                logic        pfire;
                logic        merge;
                logic        alloc;
                logic        done_next;
                logic [31:0] e_ld;
                logic [3:0]  e_lbe;
                push_valid  = ($urandom_range(0, 3) != 0);
                push_addr   = 32'h100 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
                push_be     = 4'($urandom_range(1, 15));
                push_data   = $urandom;
                drain_ready = ($urandom_range(0, 1) == 1);
                load_addr   = 32'h100 + 4 * $urandom_range(0, 4);
                flush       = (cyc == 60 || cyc == 150);
                rst_now     = (cyc == 153);
                if (cyc >= 140 && cyc <= 153) begin
                    push_valid  = 1'b1;
                    drain_ready = 1'b0;
                end
                reset = rst_now;
                #1;
                coal   = (mq.size() > 0) && (mq[$].w == push_addr[31:2]);
                e_prdy = !mflush && ((mq.size() < 4) || coal);
                e_dv   = (mq.size() > 0);
                e_ld   = '0;
                e_lbe  = '0;
                foreach (mq[j]) begin
                    if (mq[j].w == load_addr[31:2]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mq[j].be[b]) begin
                                e_ld[8*b +: 8] = mq[j].d[8*b +: 8];
                                e_lbe[b] = 1'b1;
                            end
                        end
                    end
                end
                chk("t6_count", count, mq.size());
                chk("t6_count_le_depth", count <= 4, 1);
                chk("t6_push_ready", push_ready, e_prdy);
                chk("t6_drain_valid", drain_valid, e_dv);
                chk("t6_flush_done", flush_done, mdone);
                if (e_dv) begin
                    chk("t6_drain_addr", drain_addr, {mq[0].w, 2'b00});
                    chk("t6_drain_data", drain_data, mq[0].d);
                    chk("t6_drain_be", drain_be, mq[0].be);
                end
                chk("t6_load_data", load_data, e_ld);
                chk("t6_load_hit_be", load_hit_be, e_lbe);
                @(posedge clock);
                if (rst_now) begin
                    mq.delete();
                    mflush = 1'b0;
                    mdone  = 1'b0;
                end else begin
                    dfire = e_dv && drain_ready;
                    pfire = push_valid && e_prdy;
                    merge = pfire && coal && !((mq.size() == 1) && dfire);
                    alloc = pfire && !merge;
                    done_next = 1'b0;
                    if (!mflush) begin
                        if (flush) begin
                            if (mq.size() == 0 && !alloc) done_next = 1'b1;
                            else mflush = 1'b1;
                        end
                    end else if (mq.size() == 0) begin
                        mflush = 1'b0;
                        done_next = 1'b1;
                    end
                    if (merge) begin
                        for (int b = 0; b < 4; b++) begin
                            if (push_be[b]) mq[$].d[8*b +: 8] = push_data[8*b +: 8];
                        end
                        mq[$].be = mq[$].be | push_be;
                    end
                    if (alloc) mq.push_back('{push_addr[31:2], push_data & bmask(push_be), push_be});
                    if (dfire) void'(mq.pop_front());
                    mdone = done_next;
                end
                #1;
            end
            reset = 1'b0;
            flush = 1'b0;
            push_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
